// File: rtl/cfg_frame_sequencer.sv
`timescale 1ns/1ps
// Host-side sequencer turning WRITE/APPLY/APPLY_ALL commands into 39-bit MSB-first scan frames for the CLB tile.
// Define CFG_FRAME_READBACK_EN to capture the tile chain output and expose the previous frame's data field.
module cfg_frame_sequencer #(
   parameter int FRAME_W   = 39,
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 4,
   parameter int NUM_WORDS = 13,
   parameter int HOLD_CYC  = 2
) (
   input  logic              cfg_clk,
   input  logic              cfg_rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_data,
   output logic              cfg_scan_en,
   output logic              cfg_scan_in,
   input  logic              cfg_scan_out,
   output logic              busy,
   output logic              done
`ifdef CFG_FRAME_READBACK_EN
   ,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid
`endif
);
   localparam int BIT_W  = $clog2(FRAME_W + 1);
   localparam int HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
   localparam int IDX_W  = ADDR_W + 1;

   localparam logic [1:0] OP_WRITE     = 2'b00;
   localparam logic [1:0] OP_APPLY_ALL = 2'b10;
   localparam logic [1:0] OP_NOP       = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD   = 3'd1,
      S_SHIFT  = 3'd2,
      S_HOLD   = 3'd3,
      S_NEXT   = 3'd4,
      S_FINISH = 3'd5
   } state_t;

   state_t              state;
   state_t              next_state;
   logic [1:0]          op_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   data_q;
   logic [FRAME_W-1:0]  shreg;
   logic [BIT_W-1:0]    bit_cnt;
   logic [HOLD_W-1:0]   hold_cnt;
   logic [IDX_W-1:0]    word_idx;
   logic [IDX_W-1:0]    word_nx;
   logic                last_word;
   logic                accept;
   logic [ADDR_W-1:0]   frame_addr;
   logic [FRAME_W-1:0]  frame;
   logic [FRAME_W-1:0]  shift_src;

   assign accept    = cmd_valid & cmd_ready;
   assign word_nx   = word_idx + IDX_W'(1);
   assign last_word = (word_nx >= IDX_W'(NUM_WORDS));

   // Frame builder: NEXT doubles as the load cycle for the following APPLY_ALL word
   always_comb begin
      frame_addr = addr_q;
      frame      = '0;
      if (state == S_NEXT) begin
         frame_addr = word_nx[ADDR_W-1:0];
      end else if (op_q == OP_APPLY_ALL) begin
         frame_addr = word_idx[ADDR_W-1:0];
      end else begin
         frame_addr = addr_q;
      end
      if (op_q == OP_WRITE) begin
         frame = {data_q, 3'b011, frame_addr};
      end else begin
         frame = {{DATA_W{1'b0}}, 3'b110, frame_addr};
      end
      if ((state == S_LOAD) || (state == S_NEXT)) begin
         shift_src = frame;
      end else begin
         shift_src = shreg;
      end
   end

   // Next-state logic
   always_comb begin
      next_state = state;
      case (state)
         S_IDLE: begin
            if (accept) begin
               next_state = (cmd_op == OP_NOP) ? S_FINISH : S_LOAD;
            end else begin
               next_state = S_IDLE;
            end
         end
         S_LOAD:  next_state = S_SHIFT;
         S_SHIFT: begin
            if (bit_cnt == BIT_W'(FRAME_W - 1)) begin
               next_state = S_HOLD;
            end else begin
               next_state = S_SHIFT;
            end
         end
         S_HOLD: begin
            if (hold_cnt == HOLD_W'(HOLD_CYC - 1)) begin
               next_state = (op_q == OP_APPLY_ALL) ? S_NEXT : S_FINISH;
            end else begin
               next_state = S_HOLD;
            end
         end
         S_NEXT:   next_state = last_word ? S_FINISH : S_SHIFT;
         S_FINISH: next_state = S_IDLE;
         default:  next_state = S_IDLE;
      endcase
   end

   // State, counters, shift register and registered outputs
   always_ff @(posedge cfg_clk) begin
      if (cfg_rst) begin
         state       <= S_IDLE;
         op_q        <= 2'b00;
         addr_q      <= '0;
         data_q      <= '0;
         shreg       <= '0;
         bit_cnt     <= '0;
         hold_cnt    <= '0;
         word_idx    <= '0;
         cmd_ready   <= 1'b1;
         busy        <= 1'b0;
         done        <= 1'b0;
         cfg_scan_en <= 1'b0;
         cfg_scan_in <= 1'b0;
      end else begin
         state       <= next_state;
         cmd_ready   <= (next_state == S_IDLE);
         busy        <= (next_state != S_IDLE) && (next_state != S_FINISH);
         done        <= (next_state == S_FINISH);
         cfg_scan_en <= (next_state == S_SHIFT);
         if (accept) begin
            op_q     <= cmd_op;
            addr_q   <= cmd_addr;
            data_q   <= cmd_data;
            word_idx <= '0;
         end else if (state == S_NEXT) begin
            word_idx <= word_nx;
         end
         // scan_in is registered, so the bit presented next cycle is taken from the source now
         if (next_state == S_SHIFT) begin
            cfg_scan_in <= shift_src[FRAME_W-1];
            shreg       <= {shift_src[FRAME_W-2:0], 1'b0};
         end else begin
            cfg_scan_in <= 1'b0;
         end
         bit_cnt  <= (state == S_SHIFT) ? bit_cnt + BIT_W'(1) : '0;
         hold_cnt <= (state == S_HOLD) ? hold_cnt + HOLD_W'(1) : '0;
      end
   end

`ifdef CFG_FRAME_READBACK_EN
   logic [FRAME_W-1:0]        capture;
   logic [FRAME_W-DATA_W-1:0] unused_capture_tail;
   assign unused_capture_tail = capture[FRAME_W-DATA_W-1:0];

   // Chain-tail capture, aligned with scan_en so bit k of the old frame lands at capture[k]
   always_ff @(posedge cfg_clk) begin
      if (cfg_rst) begin
         capture  <= '0;
         rd_data  <= '0;
         rd_valid <= 1'b0;
      end else begin
         if (state == S_SHIFT) begin
            capture <= {capture[FRAME_W-2:0], cfg_scan_out};
         end
         rd_valid <= (next_state == S_FINISH);
         if (next_state == S_FINISH) begin
            rd_data <= capture[FRAME_W-1 -: DATA_W];
         end
      end
   end
`else
   logic unused_scan_out;
   assign unused_scan_out = cfg_scan_out;
`endif

endmodule

// File: tb/tb_cfg_frame_sequencer.sv
`timescale 1ns/1ps
// Directed, table-driven bench for cfg_frame_sequencer with a looped-back tile chain model.
// Readback checks are compiled in when CFG_FRAME_READBACK_EN is defined.
module tb_cfg_frame_sequencer;
   logic        cfg_clk = 1'b0;
   logic        cfg_rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [1:0]  cmd_op = 2'b11;
   logic [3:0]  cmd_addr = 4'h0;
   logic [31:0] cmd_data = 32'h0;
   logic        cfg_scan_en;
   logic        cfg_scan_in;
   logic        cfg_scan_out;
   logic        busy;
   logic        done;
`ifdef CFG_FRAME_READBACK_EN
   logic [31:0] rd_data;
   logic        rd_valid;
   logic [31:0] last_rd_data = 32'h0;
   logic        last_rd_valid = 1'b0;
`endif

   cfg_frame_sequencer dut (
      .cfg_clk      (cfg_clk),
      .cfg_rst      (cfg_rst),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_op       (cmd_op),
      .cmd_addr     (cmd_addr),
      .cmd_data     (cmd_data),
      .cfg_scan_en  (cfg_scan_en),
      .cfg_scan_in  (cfg_scan_in),
      .cfg_scan_out (cfg_scan_out),
      .busy         (busy),
      .done         (done)
`ifdef CFG_FRAME_READBACK_EN
      ,
      .rd_data      (rd_data),
      .rd_valid     (rd_valid)
`endif
   );

   always #5 cfg_clk = ~cfg_clk;

   // tile scan chain: tail bit feeds back to the sequencer
   logic [38:0] tile = 39'h0;
   always @(posedge cfg_clk) if (cfg_scan_en === 1'b1) tile <= {tile[37:0], cfg_scan_in};
   assign cfg_scan_out = tile[38];

   int total = 0;
   int bad = 0;

   // stream monitor: collects frames, bit counts, inter-frame gaps, done pulses
   logic [38:0] cur = 39'h0;
   int          bits = 0;
   int          gap_run = 0;
   int          done_cnt = 0;
   bit          prev_en = 1'b0;
   logic [38:0] frames[$];
   int          fbits[$];
   int          gaps[$];

   always @(negedge cfg_clk) begin
      if (done === 1'b1) done_cnt++;
      if (cfg_scan_en === 1'b1) begin
         if (!prev_en && frames.size() > 0) gaps.push_back(gap_run);
         cur = {cur[37:0], cfg_scan_in};
         bits++;
         gap_run = 0;
      end else begin
         if (prev_en) begin
            frames.push_back(cur);
            fbits.push_back(bits);
            bits = 0;
         end
         gap_run++;
      end
      prev_en = (cfg_scan_en === 1'b1);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // issue one command; edges counts clock edges from the accepting edge until done is visible
   task automatic issue(input logic [1:0] op, input logic [3:0] a, input logic [31:0] d,
                        output int edges, output bit hs_ok, output bit done_one);
      int w;
      frames.delete(); fbits.delete(); gaps.delete();
      @(negedge cfg_clk);
      cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_data = d;
      w = 0;
      while (cmd_ready !== 1'b1 && w < 2000) begin
         @(negedge cfg_clk);
         w++;
      end
      chk("accept_ready", {63'h0, cmd_ready}, 64'h1);
      @(posedge cfg_clk); #1;
      cmd_valid = 1'b0;
      hs_ok = 1'b1;
      edges = 0;
      while (done !== 1'b1 && edges < 2000) begin
         if (cmd_ready !== 1'b0 || busy !== 1'b1) hs_ok = 1'b0;
         @(posedge cfg_clk); #1;
         edges++;
      end
      if (cmd_ready !== 1'b0 || busy !== 1'b0) hs_ok = 1'b0;
`ifdef CFG_FRAME_READBACK_EN
      last_rd_data  = rd_data;
      last_rd_valid = rd_valid;
`endif
      @(posedge cfg_clk); #1;
      done_one = (done === 1'b0) && (cmd_ready === 1'b1);
   endtask

   typedef struct {
      logic [1:0]  op;
      logic [3:0]  addr;
      logic [31:0] data;
      logic [38:0] frame;
      int          edges;
      int          nframes;
   } vec_t;

   vec_t vecs [7];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int  edges;
      bit  hs_ok;
      bit  done_one;
      int  d0;
      int  n;
      int  w;

      vecs[0] = '{2'b00, 4'h3, 32'hDEADBEEF, 39'h6F_56DF_77B3, 42, 1};
      vecs[1] = '{2'b01, 4'hA, 32'h0,        39'h00_0000_006A, 42, 1};
      vecs[2] = '{2'b11, 4'h5, 32'h1111_2222, 39'h0,           0,  0};
      vecs[3] = '{2'b00, 4'hF, 32'h0,        39'h00_0000_003F, 42, 1};
      vecs[4] = '{2'b00, 4'h0, 32'hFFFFFFFF, 39'h7F_FFFF_FFB0, 42, 1};
      vecs[5] = '{2'b00, 4'h5, 32'h12345678, 39'h09_1A2B_3C35, 42, 1};
      vecs[6] = '{2'b01, 4'hC, 32'hFFFFFFFF, 39'h00_0000_006C, 42, 1};

      // reset held three cycles
      cfg_rst = 1'b1;
      repeat (3) @(posedge cfg_clk);
      #1;
      chk("rst_ready", {63'h0, cmd_ready}, 64'h1);
      chk("rst_busy", {63'h0, busy}, 64'h0);
      chk("rst_scan_en", {63'h0, cfg_scan_en}, 64'h0);
      chk("rst_scan_in", {63'h0, cfg_scan_in}, 64'h0);
      chk("rst_done", {63'h0, done}, 64'h0);
`ifdef CFG_FRAME_READBACK_EN
      chk("rst_rd_data", {32'h0, rd_data}, 64'h0);
`endif
      cfg_rst = 1'b0;

      for (int i = 0; i < 7; i++) begin
         issue(vecs[i].op, vecs[i].addr, vecs[i].data, edges, hs_ok, done_one);
         chk($sformatf("v%0d_latency", i), edges, vecs[i].edges);
         chk($sformatf("v%0d_nframes", i), frames.size(), vecs[i].nframes);
         if (vecs[i].nframes == 1 && frames.size() == 1) begin
            chk($sformatf("v%0d_frame", i), {25'h0, frames[0]}, {25'h0, vecs[i].frame});
            chk($sformatf("v%0d_bits", i), fbits[0], 39);
         end
         chk($sformatf("v%0d_handshake", i), {63'h0, hs_ok}, 64'h1);
         chk($sformatf("v%0d_done_pulse", i), {63'h0, done_one}, 64'h1);
      end

      // APPLY_ALL sweep
      d0 = done_cnt;
      issue(2'b10, 4'h7, 32'hA5A5A5A5, edges, hs_ok, done_one);
      chk("all_latency", edges, 547);
      chk("all_nframes", frames.size(), 13);
      for (int i = 0; i < 13 && i < frames.size(); i++)
         chk($sformatf("all_frame%0d", i), {25'h0, frames[i]}, {25'h0, 32'h0, 3'b110, 4'(i)});
      chk("all_ngaps", gaps.size(), 12);
      for (int i = 0; i < gaps.size(); i++)
         chk($sformatf("all_gap%0d", i), gaps[i], 3);
      chk("all_done_count", done_cnt - d0, 1);
      chk("all_handshake", {63'h0, hs_ok}, 64'h1);

      // reset in the middle of SHIFT
      @(negedge cfg_clk);
      cmd_valid = 1'b1; cmd_op = 2'b00; cmd_addr = 4'h7; cmd_data = 32'hA5A5A5A5;
      @(posedge cfg_clk); #1;
      cmd_valid = 1'b0;
      n = 0; w = 0;
      while (n < 20 && w < 200) begin
         @(posedge cfg_clk); #1;
         w++;
         if (cfg_scan_en === 1'b1) n++;
      end
      chk("midrst_reached_shift20", n, 20);
      d0 = done_cnt;
      cfg_rst = 1'b1;
      @(posedge cfg_clk); #1;
      cfg_rst = 1'b0;
      chk("midrst_scan_en", {63'h0, cfg_scan_en}, 64'h0);
      chk("midrst_ready", {63'h0, cmd_ready}, 64'h1);
      chk("midrst_busy", {63'h0, busy}, 64'h0);
      chk("midrst_done", {63'h0, done}, 64'h0);
      repeat (60) @(posedge cfg_clk);
      #1;
      chk("midrst_no_done", done_cnt - d0, 0);
      chk("midrst_idle_scan_en", {63'h0, cfg_scan_en}, 64'h0);
      issue(2'b00, 4'h9, 32'h0F0F1234, edges, hs_ok, done_one);
      chk("post_rst_latency", edges, 42);
      chk("post_rst_nframes", frames.size(), 1);
      if (frames.size() == 1) begin
         chk("post_rst_frame", {25'h0, frames[0]}, {25'h0, 39'h07_8789_1A39});
         chk("post_rst_bits", fbits[0], 39);
      end

`ifdef CFG_FRAME_READBACK_EN
      issue(2'b00, 4'h1, 32'h12345678, edges, hs_ok, done_one);
      issue(2'b00, 4'h2, 32'h00000000, edges, hs_ok, done_one);
      chk("rb_valid", {63'h0, last_rd_valid}, 64'h1);
      chk("rb_data", {32'h0, last_rd_data}, {32'h0, 32'h12345678});
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
